// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1 -- N-to-1 registered multiplexer with valid/ready on every port.
//
// One of N input channels is selected and copied into a single output
// register. The register separates the selection logic from downstream timing.
//   MODE=0 : the channel is chosen by `sel`. Values of `sel` >= N select nothing.
//   MODE=1 : round-robin arbitration. The search starts at the channel after
//            the one that last transferred. `sel` is ignored.
//
// Handshake: a beat moves across a port on a rising edge when valid and ready
// are both high on that port. Valid must not wait for ready. Once valid is
// raised, data must stay stable until the transfer happens.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    N*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   N, per-channel valid
//   in_ready   N, per-channel ready (one-hot or zero)
//   sel        SEL_W, channel select (MODE=0 only)
//   out_data   WIDTH, registered selected data
//   out_src    SEL_W, index of the channel that produced out_data
//   out_valid  output register holds a beat
//   out_ready  downstream accepts the beat
module mux_rr_nto1 #(
  parameter int WIDTH = 5,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;   // next channel to get priority (MODE=1)

  logic             load_en;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;

  // The register can take a new beat when it is empty or is being drained.
  assign load_en = !out_valid_q || out_ready;

  // Grant selection.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // For each possible pointer value, scan the offsets from the farthest to
      // the nearest. The last match is the nearest valid channel at or after
      // the pointer, so that channel wins.
      for (int p = 0; p < N; p++) begin
        if (ptr_q == SEL_W'(p)) begin
          for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[(p + k) % N]) begin
              gnt_vld = 1'b1;
              gnt_idx = SEL_W'((p + k) % N);
            end
          end
        end
      end
    end
  end

  // Data of the granted channel.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // All ready bits are held low while reset is asserted.
  assign xfer = rst_n && load_en && gnt_vld;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
    end
  end

  // Next state of the output register and the pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = gnt_data;
        out_src_d  = gnt_idx;
      end
    end
    // The pointer moves only on a transfer. Backpressure never changes priority.
    if (MODE != 0 && xfer) begin
      ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/mux_rr_nto1.md
# mux_rr_nto1

Parametrised N-to-1 registered datapath multiplexer with valid/ready handshake on every input and on the output. It generalises the 5-bit 2-to-1 selector to N channels of WIDTH bits. A single output register decouples the selection logic from downstream timing. Two selection modes are supported: external select (MODE=0) for register-address/operand steering, and round-robin arbitration (MODE=1) for sharing one downstream port, such as a write-back or memory request path, among several sources.

## Interface
Parameters:
- WIDTH, 5, data width per channel (≥1)
- N, 4, number of input channels (≥2)
- MODE, 0, 0 = external select via `sel`; 1 = round-robin arbitration (`sel` ignored)
- SEL_W, derived as clog2(N), width of `sel`/`out_src` (localparam, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready; at most one bit high per cycle
- sel  in  SEL_W  channel select (MODE=0 only); values ≥N select nothing
- out_data  out  WIDTH  registered selected data
- out_src  out  SEL_W  index of the channel that produced out_data
- out_valid  out  1  output register holds a beat
- out_ready  in  1  downstream accepts beat

## Operation
- load_en = !out_valid | out_ready.
- Grant, combinational:
  - MODE=0: grant to `sel` iff sel<N and in_valid[sel]; otherwise no grant.
  - MODE=1: search in_valid starting at index ptr, wrapping modulo N; grant the first set bit found; no grant if in_valid is all zero.
- in_ready[g] = load_en & granted(g). All other in_ready bits are 0. in_ready may depend combinationally on out_ready, sel and in_valid.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On the next edge: out_data←in_data[g], out_src←g, out_valid←1.
- If load_en is set and there is no transfer, the output drains: out_valid←0 on the next edge. out_data and out_src hold their last values.
- If out_valid & !out_ready, out_data, out_src and out_valid are frozen and every in_ready bit is 0.
- Round-robin pointer (MODE=1 only):
  - On a transfer from g: ptr←(g+1) mod N, with wrap from N-1 to 0.
  - Without a transfer, ptr is unchanged. Backpressure therefore never rotates priority.
- MODE=0 keeps no pointer state. `sel` may change on any cycle without side effects.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, ptr=0 (channel 0 has priority first). in_ready is all zero while reset is asserted.
- Reset release is synchronous to clk. The first transfer is possible on the first edge with rst_n high.
- Latency: input transfer on edge k; out_valid is high after edge k.
- Throughput: 1 beat/cycle when out_ready is held high. There are no bubbles on simultaneous drain and load.
- A simultaneous output handshake and input transfer in the same cycle replaces the register contents. No beat is lost or duplicated.
- Reset asserted mid-transfer discards the held beat immediately. Upstream must re-present data after reset.
- Once asserted, in_valid/in_data from a source must stay stable until in_ready is seen (standard handshake). The block does not check this.

## Test plan
- Reset: hold rst_n=0 with in_valid=4'b1111 → out_valid=0, out_data=0, out_src=0, in_ready=0. Release → first edge captures ch0 (MODE=1).
- MODE=0 pass-through: sel=2, in_data ch2=5'h15, in_valid=4'b0100, out_ready=1 → in_ready=4'b0100; next cycle out_data=5'h15, out_src=2. With sel=1 and in_valid[1]=0 → no grant; out_valid drops after one cycle.
- Backpressure: load ch3=5'h0A, then out_ready=0 for 3 cycles while ch0 is valid → out_data=5'h0A and out_src=3 stay stable, in_ready=0. Raise out_ready → ch0 loads on the same edge that ch3 drains.
- MODE=1 fairness: in_valid=4'b1111 continuously, out_ready=1 → out_src sequence 0,1,2,3,0,1.
- MODE=1 skip and wrap: ptr=3, in_valid=4'b0010 → grant ch1, then ptr=2. Then in_valid=4'b1001 → grant ch3, then ptr=0 → next grant ch0.
- Reset mid-stream: assert rst_n low asynchronously between edges while out_valid=1 → out_valid=0 immediately; after release, round-robin restarts from ch0.
